soc_bus_xbar: RTL and testbench
===============================

# soc_bus_xbar

Parametrised shared-bus interconnect for the RISC-V SoC. It arbitrates N_MASTERS requesters (core data port, UART ROM loader, future DMA) onto N_SLAVES memory-mapped targets (rom, ram, uart, GPIO). It replaces fixed point-to-point wiring in the SoC top. Features: round-robin arbitration, address-field slave decode, a request/acknowledge slave handshake, a bus timeout, and error responses for unmapped addresses or hung slaves.

## Interface
- N_MASTERS, 2, number of masters (1..8)
- N_SLAVES, 4, number of slaves (1..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- SEL_HI, 31, MSB of the slave-select address field
- SEL_LO, 28, LSB of the slave-select address field
- TIMEOUT, 255, maximum cycles to wait for a slave ack (≥1)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset, synchronous, active-high
- m_req  in  N_MASTERS  per-master request; held until that master's m_rvalid
- m_we  in  N_MASTERS  1 = write, 0 = read
- m_addr  in  N_MASTERS*ADDR_W  flattened; master i at [i*ADDR_W +: ADDR_W]
- m_wdata  in  N_MASTERS*DATA_W  flattened write data
- m_gnt  out  N_MASTERS  one-cycle pulse: request accepted
- m_rvalid  out  N_MASTERS  one-cycle pulse: transaction complete
- m_rdata  out  DATA_W  read data, valid with m_rvalid
- m_err  out  1  error flag, valid with m_rvalid
- s_req  out  N_SLAVES  one-hot slave strobe, held until ack or timeout
- s_we  out  1  write enable to all slaves
- s_addr  out  ADDR_W  latched address to all slaves
- s_wdata  out  DATA_W  latched write data to all slaves
- s_ack  in  N_SLAVES  slave completion; may assert in the first cycle s_req is high
- s_rdata  in  N_SLAVES*DATA_W  flattened per-slave read data, valid with s_ack
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states are IDLE, BUSY and RESP. The FSM and all outputs are registered.
- **IDLE:** when any m_req bit is set, pick grant index g by round-robin.
  - The search starts at last_g+1 (mod N_MASTERS).
  - Latch m_we/m_addr/m_wdata of master g into s_we/s_addr/s_wdata.
  - Set m_gnt[g] and update last_g.
  - Decode sel = addr[SEL_HI:SEL_LO].
  - If sel < N_SLAVES: set s_req[sel] and go to BUSY.
  - Otherwise it is a decode error: go directly to RESP with err=1 and rdata=0. No s_req is issued.
- **BUSY:** a wait counter increments each cycle.
  - On s_ack[sel]: drop s_req, capture s_rdata[sel] (0 for writes), set err=0, go to RESP.
  - If the counter reaches TIMEOUT-1 with no ack: drop s_req, set err=1 and rdata=0, go to RESP.
  - If ack arrives in the same cycle as the timeout, ack wins.
  - Acks from unselected slaves are ignored.
- **RESP:** assert m_rvalid[g] for one cycle with m_rdata and m_err, then go to IDLE.
  - Writes also receive m_rvalid as a completion.
- Master rule: m_req must be low, or carry a new request, in the cycle after m_rvalid. The IDLE state samples m_req again.
- Masters are never granted while the bus is busy. Requests wait without limit; round-robin guarantees each waits at most N_MASTERS-1 transactions.
- Reset values: state=IDLE, last_g=N_MASTERS-1 (so master 0 wins first). All of m_gnt, m_rvalid, m_rdata, m_err, s_req, s_we, s_addr, s_wdata, busy and the counter reset to 0.
- Reset mid-transaction: on the next edge, s_req drops and no m_rvalid is issued. The transaction is lost and masters must retry.
- Counter width is clog2(TIMEOUT+1); the counter clears on every entry to BUSY.

## Timing
- Cycle 0: m_req seen in IDLE.
- Cycle 1: m_gnt pulse, and s_req/s_addr valid (BUSY).
- With ack in cycle 1: cycle 2 is RESP with m_rvalid, and cycle 3 is IDLE.
- Minimum latency is 2 cycles from request to m_rvalid. Peak throughput is one transaction per 3 cycles.
- Decode error: m_gnt and m_rvalid in consecutive cycles (cycles 1 and 2); s_req is never asserted.
- Timeout: m_rvalid with m_err=1 occurs exactly TIMEOUT+1 cycles after m_gnt.
- s_addr, s_we and s_wdata are stable for the whole time s_req is high.

## Test plan
- **Single read:** master 0 reads addr 0x1000_0004, slave 1 acks at once with 0xDEADBEEF -> m_gnt[0] in cycle 1, s_req=4'b0010, m_rvalid[0] in cycle 2, m_rdata=0xDEADBEEF, m_err=0.
- **Round-robin:** both masters hold requests for 4 transactions -> grants go 0,1,0,1. Each m_rvalid goes to the granted master only.
- **Decode error:** with N_SLAVES=4, read 0x5000_0000 -> s_req stays 0, m_rvalid with m_err=1 and m_rdata=0 in cycle 2.
- **Timeout:** TIMEOUT=8, slave 2 never acks -> s_req[2] is high for 8 cycles, m_err=1 on m_rvalid 9 cycles after m_gnt. A next request is accepted afterwards.
- **Ack on timeout cycle and stray ack:** slave acks in the 8th BUSY cycle -> m_err=0 with data. An ack from an unselected slave during BUSY -> no effect.
- **Reset mid-op:** rst asserted in BUSY -> next edge s_req=0, busy=0, no m_rvalid. The first request after reset goes to master 0.

Source files
------------

// File: rtl/soc_bus_xbar.sv
`default_nettype none
// ============================================================================
// Module   : soc_bus_xbar
// Function : round-robin N-master to N-slave shared bus with decode/timeout errors
// Revision : 1.0 - initial release
// ============================================================================
module soc_bus_xbar #(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int SEL_HI    = 31,
    parameter int SEL_LO    = 28,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS-1:0]          m_we,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    output logic [N_MASTERS-1:0]          m_gnt,
    output logic [N_MASTERS-1:0]          m_rvalid,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          m_err,
    output logic [N_SLAVES-1:0]           s_req,
    output logic                          s_we,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic [N_SLAVES-1:0]           s_ack,
    input  logic [N_SLAVES*DATA_W-1:0]    s_rdata,
    output logic                          busy
);
    localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int SW = SEL_HI - SEL_LO + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state, w_state;
    logic [GW-1:0]       r_last_g, w_last_g;
    logic [GW-1:0]       r_g, w_g;
    logic [SW-1:0]       r_sel, w_sel;
    logic [CW-1:0]       r_cnt, w_cnt;

    logic                w_found;
    logic [GW-1:0]       w_pick;
    logic                w_pick_we;
    logic [ADDR_W-1:0]   w_pick_addr;
    logic [DATA_W-1:0]   w_pick_wdata;
    logic [SW-1:0]       w_pick_sel;
    logic                w_dec_ok;
    logic                w_ack;
    logic [DATA_W-1:0]   w_ack_rdata;

    logic [N_MASTERS-1:0] w_gnt, w_rvalid;
    logic [DATA_W-1:0]    w_rdata;
    logic                 w_err;
    logic [N_SLAVES-1:0]  w_s_req;
    logic                 w_s_we;
    logic [ADDR_W-1:0]    w_s_addr;
    logic [DATA_W-1:0]    w_s_wdata;

    // Round-robin: first requester above last_g, else wrap around from index 0.
    always_comb begin
        w_found      = 1'b0;
        w_pick       = '0;
        w_pick_we    = 1'b0;
        w_pick_addr  = '0;
        w_pick_wdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (!w_found && m_req[i] && (GW'(i) > r_last_g)) begin
                w_found = 1'b1;
                w_pick  = GW'(i);
            end
        end
        for (int i = 0; i < N_MASTERS; i++) begin
            if (!w_found && m_req[i] && (GW'(i) <= r_last_g)) begin
                w_found = 1'b1;
                w_pick  = GW'(i);
            end
        end
        for (int i = 0; i < N_MASTERS; i++) begin
            if (w_pick == GW'(i)) begin
                w_pick_we    = m_we[i];
                w_pick_addr  = m_addr[i*ADDR_W +: ADDR_W];
                w_pick_wdata = m_wdata[i*DATA_W +: DATA_W];
            end
        end
        w_pick_sel = w_pick_addr[SEL_HI:SEL_LO];
        w_dec_ok   = (32'(w_pick_sel) < 32'(N_SLAVES));
    end

    always_comb begin
        w_ack       = 1'b0;
        w_ack_rdata = '0;
        for (int s = 0; s < N_SLAVES; s++) begin
            if (r_sel == SW'(s)) begin
                w_ack       = s_ack[s];
                w_ack_rdata = s_rdata[s*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state   = r_state;
        w_last_g  = r_last_g;
        w_g       = r_g;
        w_sel     = r_sel;
        w_cnt     = r_cnt;
        w_gnt     = '0;
        w_rvalid  = '0;
        w_rdata   = m_rdata;
        w_err     = m_err;
        w_s_req   = s_req;
        w_s_we    = s_we;
        w_s_addr  = s_addr;
        w_s_wdata = s_wdata;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_gnt[w_pick] = 1'b1;
                    w_last_g      = w_pick;
                    w_g           = w_pick;
                    w_sel         = w_pick_sel;
                    w_cnt         = '0;
                    w_s_we        = w_pick_we;
                    w_s_addr      = w_pick_addr;
                    w_s_wdata     = w_pick_wdata;
                    w_s_req       = '0;
                    for (int s = 0; s < N_SLAVES; s++) begin
                        if (w_pick_sel == SW'(s)) begin
                            w_s_req[s] = 1'b1;
                        end
                    end
                    if (w_dec_ok) begin
                        w_state = ST_BUSY;
                    end else begin
                        w_err   = 1'b1;
                        w_rdata = '0;
                        w_state = ST_RESP;
                    end
                end
            end
            ST_BUSY: begin
                w_cnt = r_cnt + 1'b1;
                if (w_ack) begin
                    w_s_req          = '0;
                    w_rdata          = s_we ? '0 : w_ack_rdata;
                    w_err            = 1'b0;
                    w_rvalid[r_g]    = 1'b1;
                    w_state          = ST_RESP;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_s_req = '0;
                    w_err   = 1'b1;
                    w_rdata = '0;
                    w_state = ST_RESP;
                end
            end
            ST_RESP: begin
                // Error paths enter RESP without m_rvalid and raise it one cycle later.
                if (|m_rvalid) begin
                    w_state = ST_IDLE;
                end else begin
                    w_rvalid[r_g] = 1'b1;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_last_g <= GW'(N_MASTERS - 1);
            r_g      <= '0;
            r_sel    <= '0;
            r_cnt    <= '0;
            m_gnt    <= '0;
            m_rvalid <= '0;
            m_rdata  <= '0;
            m_err    <= 1'b0;
            s_req    <= '0;
            s_we     <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            busy     <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_last_g <= w_last_g;
            r_g      <= w_g;
            r_sel    <= w_sel;
            r_cnt    <= w_cnt;
            m_gnt    <= w_gnt;
            m_rvalid <= w_rvalid;
            m_rdata  <= w_rdata;
            m_err    <= w_err;
            s_req    <= w_s_req;
            s_we     <= w_s_we;
            s_addr   <= w_s_addr;
            s_wdata  <= w_s_wdata;
            busy     <= (w_state != ST_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_soc_bus_xbar.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_bus_xbar
// Function : scoreboard bench for soc_bus_xbar with behavioural slaves
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_bus_xbar;
    localparam int NM = 2;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NM-1:0]     m_req, m_we, m_gnt, m_rvalid;
    logic [NM*AW-1:0]  m_addr;
    logic [NM*DW-1:0]  m_wdata;
    logic [DW-1:0]     m_rdata;
    logic              m_err;
    logic [NS-1:0]     s_req, s_ack;
    logic              s_we, busy;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [NS*DW-1:0]  s_rdata;

    soc_bus_xbar #(
        .N_MASTERS(NM), .N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
        .SEL_HI(31), .SEL_LO(28), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata), .busy(busy)
    );

    always #10 clk = ~clk;

    // Slave s returns addr ^ KEY[s]; ack delay (cycles after first s_req cycle) is addr[11:8].
    logic [31:0] KEY [NS] = '{32'h0BAD_F00D, 32'hCEAD_BEEB, 32'h1234_5678, 32'h8765_4321};

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          sreq_cycles;
    } txn_t;

    txn_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   idle_sreq_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic txn_t model(input int m, input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata);
        txn_t t;
        int   sel;
        int   d;
        sel     = int'(addr[31:28]);
        d       = int'(addr[11:8]);
        t.m     = m;
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        if (sel >= NS) begin
            t.err = 1'b1; t.rdata = '0; t.lat = 1; t.sreq_cycles = 0;
        end else if (d >= TO) begin
            t.err = 1'b1; t.rdata = '0; t.lat = TO + 1; t.sreq_cycles = TO;
        end else begin
            t.err = 1'b0; t.rdata = we ? 32'h0 : (addr ^ KEY[sel]);
            t.lat = d + 1; t.sreq_cycles = d + 1;
        end
        return t;
    endfunction

    // Behavioural slaves; unselected slaves emit random stray acks.
    initial begin
        int scnt [NS];
        s_ack   = '0;
        s_rdata = '0;
        for (int s = 0; s < NS; s++) scnt[s] = 0;
        forever begin
            @(negedge clk);
            for (int s = 0; s < NS; s++) begin
                s_rdata[s*DW +: DW] = s_addr ^ KEY[s];
                if (s_req[s]) begin
                    scnt[s]++;
                    s_ack[s] = ((scnt[s] - 1) == int'(s_addr[11:8]));
                end else begin
                    scnt[s]  = 0;
                    s_ack[s] = ($urandom_range(0, 3) == 0);
                end
            end
        end
    end

    // Monitor: round-robin grant model plus per-transaction response checks.
    initial begin
        logic [NM-1:0] prev_req;
        int            exp_last;
        bit            in_txn;
        txn_t          cur;
        int            cyc, gnt_cyc, sreq_cnt, g, idx;
        bit            bad;
        logic [NS-1:0] exp_onehot;
        prev_req = '0; exp_last = NM - 1; in_txn = 1'b0; cyc = 0; gnt_cyc = 0;
        sreq_cnt = 0; bad = 1'b0; exp_onehot = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_last = NM - 1;
                in_txn   = 1'b0;
                exp_q.delete();
            end else begin
                if (m_gnt != '0) begin
                    g = -1;
                    for (int k = 1; k <= NM; k++)
                        if (g < 0 && prev_req[(exp_last + k) % NM]) g = (exp_last + k) % NM;
                    check("gnt_vector", 64'(m_gnt), (g >= 0) ? 64'(1 << g) : 64'd0);
                    check("gnt_while_busy", 64'(in_txn), 64'd0);
                    if (g >= 0) exp_last = g;
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++)
                        if (idx < 0 && exp_q[i].m == g) idx = i;
                    check("gnt_has_request", 64'(idx >= 0), 64'd1);
                    if (idx >= 0) begin
                        cur = exp_q[idx];
                        exp_q.delete(idx);
                        in_txn     = 1'b1;
                        gnt_cyc    = cyc;
                        sreq_cnt   = 0;
                        bad        = 1'b0;
                        exp_onehot = (int'(cur.addr[31:28]) < NS) ? NS'(1 << cur.addr[31:28]) : '0;
                    end
                end
                if (s_req != '0) begin
                    if (in_txn) begin
                        sreq_cnt++;
                        if (s_req != exp_onehot || s_addr != cur.addr ||
                            s_we != cur.we || s_wdata != cur.wdata) bad = 1'b1;
                    end else begin
                        idle_sreq_seen = 1'b1;
                    end
                end
                if (m_rvalid != '0) begin
                    if (!in_txn) begin
                        check("rvalid_unexpected", 64'(m_rvalid), 64'd0);
                    end else begin
                        check("rvalid_vector", 64'(m_rvalid), 64'(1 << cur.m));
                        check("rdata", 64'(m_rdata), 64'(cur.rdata));
                        check("err", 64'(m_err), 64'(cur.err));
                        check("latency", 64'(cyc - gnt_cyc), 64'(cur.lat));
                        check("sreq_cycles", 64'(sreq_cnt), 64'(cur.sreq_cycles));
                        check("slave_side_stable", 64'(bad), 64'd0);
                        in_txn = 1'b0;
                    end
                end
            end
            prev_req = m_req;
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic issue(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        int budget;
        exp_q.push_back(model(m, we, addr, wdata));
        m_req[m]             = 1'b1;
        m_we[m]              = we;
        m_addr[m*AW +: AW]   = addr;
        m_wdata[m*DW +: DW]  = wdata;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!m_rvalid[m] && budget < 200);
        if (!m_rvalid[m]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rvalid_wait m%0d: no m_rvalid after %0d cycles, expected one", m, budget);
        end
        rd = m_rdata;
        er = m_err;
        @(posedge clk);
        #1;
        m_req[m] = 1'b0;
    endtask

    task automatic rand_master(input int m, input int n);
        logic [31:0] rd, a, wd;
        logic        er, w;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            a        = $urandom;
            a[31:28] = 4'($urandom_range(0, 5));
            a[11:8]  = 4'($urandom_range(0, 10));
            w        = 1'($urandom_range(0, 1));
            wd       = $urandom;
            issue(m, w, a, wd, rd, er);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          budget;
        bit          seen;
        rst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 64'(m_gnt), 64'd0);
        check("rst_rvalid", 64'(m_rvalid), 64'd0);
        check("rst_sreq", 64'(s_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rdata_err", 64'({m_rdata, m_err}), 64'd0);
        check("rst_slave_bus", 64'({s_we, s_addr, s_wdata}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(0, 1'b0, 32'h1000_0004, 32'h0, rd, er);
        check("single_read_data", 64'(rd), 64'hDEAD_BEEF);
        check("single_read_err", 64'(er), 64'd0);
        issue(0, 1'b0, 32'h5000_0000, 32'h0, rd, er);
        check("decode_err_flag", 64'({rd, er}), 64'd1);
        issue(1, 1'b0, 32'h2000_0F00, 32'h0, rd, er);
        check("timeout_err_flag", 64'({rd, er}), 64'd1);
        issue(0, 1'b0, 32'h3000_0700, 32'h0, rd, er);
        check("ack_on_last_cycle_err", 64'(er), 64'd0);
        issue(1, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, rd, er);

        fork
            begin
                logic [31:0] r0; logic e0;
                issue(0, 1'b0, 32'h0000_0110, 32'h0, r0, e0);
                issue(0, 1'b1, 32'h2000_0220, 32'h1111_2222, r0, e0);
            end
            begin
                logic [31:0] r1; logic e1;
                issue(1, 1'b0, 32'h3000_0030, 32'h0, r1, e1);
                issue(1, 1'b0, 32'h1000_0340, 32'h0, r1, e1);
            end
        join

        // Reset while a transaction is stuck in BUSY.
        exp_q.push_back(model(0, 1'b0, 32'h2000_0F00, 32'h0));
        m_req[0] = 1'b1; m_we[0] = 1'b0; m_addr[0 +: AW] = 32'h2000_0F00;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!m_gnt[0] && budget < 20);
        check("midop_gnt_seen", 64'(m_gnt[0]), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        m_req[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midop_rst_sreq", 64'(s_req), 64'd0);
        check("midop_rst_busy", 64'(busy), 64'd0);
        check("midop_rst_rvalid", 64'(m_rvalid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (m_rvalid != '0 || m_gnt != '0) seen = 1'b1;
        end
        check("midop_no_late_response", 64'(seen), 64'd0);
        @(posedge clk);
        #1;

        fork
            begin
                logic [31:0] r0; logic e0;
                issue(0, 1'b0, 32'h0000_0100, 32'h0, r0, e0);
            end
            begin
                logic [31:0] r1; logic e1;
                issue(1, 1'b0, 32'h1000_0000, 32'h0, r1, e1);
            end
        join

        fork
            rand_master(0, 30);
            rand_master(1, 30);
        join

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("no_sreq_outside_txn", 64'(idle_sreq_seen), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
